// File: rtl/yapp_router_pkg.sv
// Shared types and constants for the N-channel YAPP router: input FSM states,
// HBUS register map and register reset values.
package yapp_router_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StParity,
        StDrop
    } yapp_state_e;

    localparam logic [7:0] REG_MAXPKT = 8'h00;
    localparam logic [7:0] REG_EN     = 8'h01;
    localparam logic [7:0] REG_DROP   = 8'h02;

    localparam int unsigned MAXPKT_RST = 63;

endpackage

// File: rtl/yapp_router_nch_if.sv
// YAPP input stream, channel outputs and HBUS grouped into one bundle.
// The router takes the slave side; the environment drives the master side.
interface yapp_router_nch_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 3
);
    logic [DATA_WIDTH-1:0]        in_data;
    logic                         in_data_vld;
    logic                         in_suspend;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_data_vld;
    logic [NUM_CH-1:0]            ch_suspend;
    logic [7:0]                   haddr;
    logic [7:0]                   hdata_w;
    logic [7:0]                   hdata_r;
    logic                         hen;
    logic                         hwr_rd;
    logic                         error;

    modport slave (
        input  in_data, in_data_vld, ch_suspend, haddr, hdata_w, hen, hwr_rd,
        output in_suspend, ch_data, ch_data_vld, hdata_r, error
    );

    modport master (
        output in_data, in_data_vld, ch_suspend, haddr, hdata_w, hen, hwr_rd,
        input  in_suspend, ch_data, ch_data_vld, hdata_r, error
    );
endinterface

// File: rtl/yapp_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty/almost-full (one free slot) flags.
// Pushes while full and pops while empty are ignored; o_data reads 0 when empty.
module yapp_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_count       = r_wr_ptr - r_rd_ptr;
    assign o_full        = (w_count == FULL_CNT);
    assign o_empty       = (w_count == '0);
    assign o_almost_full = (w_count >= AFULL_CNT);
    assign w_do_push     = i_push && !o_full;
    assign w_do_pop      = i_pop && !o_empty;
    assign o_data        = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/yapp_router_nch.sv
// YAPP packet router: one byte-serial input, NUM_CH FIFO-backed output channels, HBUS config.
// Define YAPP_ROUTER_PARITY_CHK_EN to build the parity checker that drives error.
module yapp_router_nch
    import yapp_router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned ADDR_BITS  = 2,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input logic              clk,
    input logic              rst_n,
    yapp_router_nch_if.slave bus
);
    localparam int unsigned LEN_W = DATA_WIDTH - ADDR_BITS;

    yapp_state_e          r_state, w_state_nxt;
    logic [LEN_W-1:0]     r_len_cnt, w_len_cnt_nxt;
    logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
    logic [LEN_W-1:0]     r_max_pkt;
    logic                 r_router_en;
    logic [7:0]           r_drop_cnt;
    logic [7:0]           r_hdata_r;

    logic [ADDR_BITS-1:0]  w_hdr_addr;
    logic [LEN_W-1:0]      w_hdr_len;
    logic                  w_accept, w_route, w_drop_evt, w_in_suspend;
    logic                  w_push_en, w_full_cur, w_hwr, w_hrd;
    logic [ADDR_BITS-1:0]  w_push_addr;
    logic [NUM_CH-1:0]     w_push, w_pop, w_full, w_empty, w_afull;
    logic [DATA_WIDTH-1:0] w_fifo_data [NUM_CH];
    logic [NUM_CH*DATA_WIDTH-1:0] w_ch_data;

    assign w_hdr_addr = bus.in_data[ADDR_BITS-1:0];
    assign w_hdr_len  = bus.in_data[DATA_WIDTH-1:ADDR_BITS];
    assign w_accept   = bus.in_data_vld && !w_in_suspend;
    assign w_route    = (32'(w_hdr_addr) < NUM_CH) && (w_hdr_len != '0) &&
                        (w_hdr_len <= r_max_pkt) && r_router_en;
    assign w_hwr      = bus.hen && bus.hwr_rd;
    assign w_hrd      = bus.hen && !bus.hwr_rd;

    always_comb begin
        w_state_nxt   = r_state;
        w_len_cnt_nxt = r_len_cnt;
        w_addr_nxt    = r_addr;
        w_push_en     = 1'b0;
        w_push_addr   = r_addr;
        w_drop_evt    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_len_cnt_nxt = w_hdr_len;
                    if (w_route) begin
                        w_addr_nxt  = w_hdr_addr;
                        w_push_en   = 1'b1;
                        w_push_addr = w_hdr_addr;
                        w_state_nxt = StPayload;
                    end else begin
                        w_drop_evt  = 1'b1;
                        w_state_nxt = StDrop;
                    end
                end
            end
            StPayload: begin
                if (w_accept) begin
                    w_push_en     = 1'b1;
                    w_len_cnt_nxt = r_len_cnt - 1'b1;
                    if (r_len_cnt == LEN_W'(1)) w_state_nxt = StParity;
                end
            end
            StParity: begin
                if (w_accept) begin
                    w_push_en   = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            StDrop: begin
                // Length was loaded from the header, so this eats length+1 bytes.
                if (w_accept) begin
                    w_len_cnt_nxt = r_len_cnt - 1'b1;
                    if (r_len_cnt == '0) w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_push     = '0;
        w_full_cur = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_push[i] = w_push_en && (32'(w_push_addr) == i);
            if (32'(r_addr) == i) w_full_cur = w_full[i];
        end
    end

    // Header guard keeps two slots free everywhere so a routed header never stalls.
    always_comb begin
        w_in_suspend = 1'b0;
        if (!rst_n) begin
            w_in_suspend = 1'b1;
        end else begin
            unique case (r_state)
                StPayload, StParity: w_in_suspend = w_full_cur;
                StIdle:              w_in_suspend = |w_afull;
                default:             w_in_suspend = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_len_cnt <= '0;
            r_addr    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_len_cnt <= w_len_cnt_nxt;
            r_addr    <= w_addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_pkt   <= LEN_W'(MAXPKT_RST);
            r_router_en <= 1'b1;
            r_drop_cnt  <= '0;
            r_hdata_r   <= '0;
        end else begin
            if (w_hwr && bus.haddr == REG_MAXPKT) r_max_pkt <= bus.hdata_w[LEN_W-1:0];
            if (w_hwr && bus.haddr == REG_EN)     r_router_en <= bus.hdata_w[0];
            if (w_hwr && bus.haddr == REG_DROP) begin
                r_drop_cnt <= '0;
            end else if (w_drop_evt && r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_hrd) begin
                case (bus.haddr)
                    REG_MAXPKT: r_hdata_r <= 8'(r_max_pkt);
                    REG_EN:     r_hdata_r <= {7'd0, r_router_en};
                    REG_DROP:   r_hdata_r <= r_drop_cnt;
                    default:    r_hdata_r <= '0;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        yapp_sync_fifo #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_push        (w_push[g]),
            .i_data        (bus.in_data),
            .i_pop         (w_pop[g]),
            .o_data        (w_fifo_data[g]),
            .o_full        (w_full[g]),
            .o_empty       (w_empty[g]),
            .o_almost_full (w_afull[g])
        );
    end

    assign w_pop = ~w_empty & ~bus.ch_suspend;

    always_comb begin
        w_ch_data = '0;
        for (int i = 0; i < NUM_CH; i++) w_ch_data[i*DATA_WIDTH +: DATA_WIDTH] = w_fifo_data[i];
    end

    assign bus.ch_data     = w_ch_data;
    assign bus.ch_data_vld = ~w_empty;
    assign bus.in_suspend  = w_in_suspend;
    assign bus.hdata_r     = r_hdata_r;

`ifdef YAPP_ROUTER_PARITY_CHK_EN
    logic [DATA_WIDTH-1:0] r_parity;
    logic                  r_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= '0;
            r_error  <= 1'b0;
        end else begin
            r_error <= 1'b0;
            if (w_accept) begin
                if (r_state == StIdle && w_route) r_parity <= bus.in_data;
                if (r_state == StPayload)         r_parity <= r_parity ^ bus.in_data;
                if (r_state == StParity)          r_error  <= (bus.in_data != r_parity);
            end
        end
    end

    assign bus.error = r_error;
`else
    assign bus.error = 1'b0;
`endif

endmodule
